store_rmw_ctrl: RTL and testbench
=================================

// Module: store_rmw_ctrl
// PURPOSE
//   Sequences every load/store from the MEM stage onto a word-only, single-port data RAM.
//   The RAM has synchronous read and whole-word write.
//   Byte/halfword stores run as read-modify-write: read word, merge lane, write word back.
//   Sits between the store-data gating logic and data memory; the stall holds the pipeline while busy.
// PARAMETERS
//   ALIGN_CHK  1  1: misaligned half/word accesses return out_err and never touch memory; 0: low addr bits ignored
// PORTS
//   clk         in   1   clock, rising edge
//   rst_n       in   1   synchronous reset, active low
//   in_req      in   1   access request valid
//   in_we       in   2   00 load word, 01 store byte, 10 store half, 11 store word
//   in_address  in   32  byte address from ALU
//   in_wd       in   32  store data (byte in [7:0], half in [15:0])
//   out_ready   out  1   controller idle, request accepted this cycle
//   out_stall   out  1   = in_req & ~out_ready, to hazard unit
//   out_done    out  1   one-cycle completion pulse
//   out_err     out  1   misaligned flag, valid only with out_done
//   out_rd      out  32  loaded word, valid with out_done for loads; else holds last value
//   mem_addr    out  32  word address {addr[31:2],2'b00}
//   mem_re      out  1   read strobe; mem_rd valid on the following cycle
//   mem_we      out  1   whole-word write strobe
//   mem_wd      out  32  write word
//   mem_rd      in   32  read data
// BEHAVIOUR
//   Single clock, synchronous active-low reset, no other reset.
//   Reset values: state IDLE, out_done=0, out_err=0, out_rd=0, mem_re=0, mem_we=0, mem_wd=0, mem_addr=0, out_ready=0.
//   out_ready=1 only in IDLE with rst_n=1. Accept = in_req & out_ready.
//   On accept, we/address/wd are captured; later in_* changes are ignored.
//   States: IDLE, RD, CAP, WR, RSP. Moore outputs; mem_re/mem_we also ANDed with rst_n, so no memory access in a reset cycle.
//   Accept at cycle T:
//     load        T+1 RD(mem_re) -> T+2 CAP(data_q<=mem_rd) -> T+3 RSP(out_done, out_rd=data_q) -> IDLE
//     byte/half   T+1 RD -> T+2 CAP(data_q<=merge(mem_rd)) -> T+3 WR(mem_we, mem_wd=data_q) -> T+4 RSP -> IDLE
//     word store  T+1 WR(mem_we, mem_wd=wd) -> T+2 RSP -> IDLE
//     misaligned  T+1 RSP(out_done, out_err=1), no mem_re/mem_we -> IDLE
//   Next accept is possible in the cycle after RSP (IDLE). Throughput: 1 load per 4 clk, 1 sub-word store per 5, 1 word store per 3.
//   Merge is little-endian. Byte: lane addr[1:0], lane k = bits [8k+7:8k], other lanes kept from mem_rd.
//   Half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
//   Misaligned (ALIGN_CHK=1): half with addr[0]=1; word load/store with addr[1:0]!=0. Byte is never misaligned.
//   mem_addr is driven from the captured address in RD, CAP and WR; otherwise it holds its value.
//   out_rd updates only in a load RSP. Stores leave it unchanged.
//   Reset mid-operation: state -> IDLE at the edge; pending write is dropped; no out_done for the aborted op.
//   in_req held high across a completed op is a new request, re-accepted in IDLE.
//   Illegal state encoding -> IDLE.
// TESTING
//   1 reset: rst_n=0 2 clk -> all outputs 0, out_ready=0; release -> out_ready=1 next clk.
//   2 word store 0x100, wd=0xDEADBEEF -> mem_we only at T+1, mem_addr=0x100, mem_wd=0xDEADBEEF; out_done at T+2.
//   3 byte store 0x103, wd=0x000000AA, mem_rd=0x11223344 -> mem_re T+1, mem_we T+3 with mem_wd=0xAA223344; done T+4.
//   4 half store 0x202, wd=0x5566, mem_rd=0x11223344 -> mem_wd=0x55663344; load 0x200 returns out_rd=mem_rd at T+3.
//   5 half store 0x201 (ALIGN_CHK=1) -> out_done+out_err at T+1, mem_re/mem_we never high; repeat ALIGN_CHK=0 -> normal RMW.
//   6 assert rst_n=0 in a sub-word store's WR cycle -> mem_we=0 that cycle, no out_done, IDLE next; new load completes normally.

Source files
------------

// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: sequences MEM-stage loads and stores onto a word-only,
// single-port data RAM with synchronous read. Byte and halfword stores run as
// read-modify-write: read the word, merge the lane, write the whole word back.
//
// Handshake: a request is taken in the cycle where in_req and out_ready are
// both high (out_ready is high only while idle and out of reset). in_we,
// in_address and in_wd are captured in that cycle and ignored afterwards.
// Completion is a single-cycle out_done pulse; out_err and out_rd are
// meaningful only alongside it. While busy, out_stall holds the pipeline.
module store_rmw_ctrl #(
  parameter bit ALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_req,
  input  logic [1:0]  in_we,
  input  logic [31:0] in_address,
  input  logic [31:0] in_wd,
  output logic        out_ready,
  output logic        out_stall,
  output logic        out_done,
  output logic        out_err,
  output logic [31:0] out_rd,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Captured request fields (only what later states need).
  logic [1:0]  we_q;
  logic [1:0]  lane_q;
  logic [15:0] wd_q;
  logic        err_q;

  // Word headed for the RAM write port (also holds captured load data).
  logic [31:0] data_q;

  logic        accept;
  logic        misaligned;
  logic [31:0] merged;

  assign out_ready = rst_n & (state == IDLE);
  assign accept    = in_req & out_ready;
  assign out_stall = in_req & ~out_ready;

  // Moore outputs; strobes are gated by reset so a reset cycle never touches memory.
  assign mem_re    = rst_n & (state == RD);
  assign mem_we    = rst_n & (state == WR);
  assign out_done  = rst_n & (state == RSP);
  assign out_err   = rst_n & (state == RSP) & err_q;
  assign mem_wd    = data_q;

  // Alignment check on the incoming request; bytes can never be misaligned.
  always_comb begin
    misaligned = 1'b0;
    if (ALIGN_CHK) begin
      case (in_we)
        2'b10:        misaligned = in_address[0];
        2'b00, 2'b11: misaligned = |in_address[1:0];
        default:      misaligned = 1'b0;
      endcase
    end
  end

  // Little-endian lane merge of the captured store data into the read word.
  always_comb begin
    merged = mem_rd;
    if (we_q == 2'b01) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wd_q[7:0];
        2'd1:    merged[15:8]  = wd_q[7:0];
        2'd2:    merged[23:16] = wd_q[7:0];
        default: merged[31:24] = wd_q[7:0];
      endcase
    end else if (we_q == 2'b10) begin
      if (lane_q[1]) merged[31:16] = wd_q;
      else           merged[15:0]  = wd_q;
    end
  end

  // Next-state logic: loads and sub-word stores read first, word stores write directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)          state_nxt = RSP;
          else if (in_we == 2'b11) state_nxt = WR;
          else                     state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = (we_q == 2'b00) ? RSP : WR;
      WR:      state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, request capture, address/data registers and load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      we_q     <= 2'b00;
      lane_q   <= 2'b00;
      wd_q     <= 16'h0000;
      err_q    <= 1'b0;
      data_q   <= 32'h0000_0000;
      mem_addr <= 32'h0000_0000;
      out_rd   <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q   <= in_we;
        lane_q <= in_address[1:0];
        wd_q   <= in_wd[15:0];
        err_q  <= misaligned;
        if (!misaligned) begin
          // Presented from the first memory cycle (RD or WR) onward.
          mem_addr <= {in_address[31:2], 2'b00};
          if (in_we == 2'b11) data_q <= in_wd;
        end
      end
      if (state == CAP) begin
        data_q <= (we_q == 2'b00) ? mem_rd : merged;
        if (we_q == 2'b00) out_rd <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Testbench for store_rmw_ctrl: a behavioural RAM answers the DUT's memory
// port; a word-array reference model predicts stored words, load results and
// per-operation timing from the access rules.
module tb_store_rmw_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A (alignment check on) ----------------
  logic        in_req;
  logic [1:0]  in_we;
  logic [31:0] in_address, in_wd;
  logic        out_ready, out_stall, out_done, out_err;
  logic [31:0] out_rd, mem_addr, mem_wd, mem_rd;
  logic        mem_re, mem_we;

  store_rmw_ctrl #(.ALIGN_CHK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_we(in_we),
    .in_address(in_address), .in_wd(in_wd), .out_ready(out_ready),
    .out_stall(out_stall), .out_done(out_done), .out_err(out_err),
    .out_rd(out_rd), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // ---------------- DUT B (alignment check off) ----------------
  logic        in_req_b;
  logic [1:0]  in_we_b;
  logic [31:0] in_address_b, in_wd_b;
  logic        out_ready_b, out_stall_b, out_done_b, out_err_b;
  logic [31:0] out_rd_b, mem_addr_b, mem_wd_b, mem_rd_b;
  logic        mem_re_b, mem_we_b;

  store_rmw_ctrl #(.ALIGN_CHK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_req(in_req_b), .in_we(in_we_b),
    .in_address(in_address_b), .in_wd(in_wd_b), .out_ready(out_ready_b),
    .out_stall(out_stall_b), .out_done(out_done_b), .out_err(out_err_b),
    .out_rd(out_rd_b), .mem_addr(mem_addr_b), .mem_re(mem_re_b), .mem_we(mem_we_b),
    .mem_wd(mem_wd_b), .mem_rd(mem_rd_b)
  );

  // ---------------- behavioural RAMs (with a preload port) ----------------
  logic [31:0] ram_a [0:255];
  logic [31:0] ram_b [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      ram_a[pre_idx] <= pre_data;
      ram_b[pre_idx] <= pre_data;
    end else begin
      if (mem_we)   ram_a[mem_addr[9:2]]   <= mem_wd;
      if (mem_we_b) ram_b[mem_addr_b[9:2]] <= mem_wd_b;
    end
    if (mem_re)   mem_rd   <= ram_a[mem_addr[9:2]];
    if (mem_re_b) mem_rd_b <= ram_b[mem_addr_b[9:2]];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_rd;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx[7:0]; pre_data = d;
    ref_mem[idx] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One request on DUT A; expectations come from the access rules and ref_mem.
  task automatic do_op(input logic [1:0] we, input logic [31:0] addr, input logic [31:0] wd);
    int idx, sh;
    bit mis;
    logic [31:0] old_word, exp_word, word_addr;
    int exp_re, exp_wr, exp_done, re_at, wr_at, done_at, re_cnt, wr_cnt;
    idx = int'(addr[9:2]);
    word_addr = {addr[31:2], 2'b00};
    old_word = ref_mem[idx];
    mis = ((we == 2'b10) && addr[0]) || ((we == 2'b00 || we == 2'b11) && (addr[1:0] != 2'b00));
    exp_word = old_word;
    case (we)
      2'b01: begin
        sh = 8 * int'(addr[1:0]);
        exp_word = (old_word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end
      2'b10: begin
        sh = 16 * int'(addr[1]);
        exp_word = (old_word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      2'b11: exp_word = wd;
      default: ;
    endcase
    if (mis) begin
      exp_re = -1; exp_wr = -1; exp_done = 1;
    end else if (we == 2'b00) begin
      exp_re = 1; exp_wr = -1; exp_done = 3;
    end else if (we == 2'b11) begin
      exp_re = -1; exp_wr = 1; exp_done = 2;
    end else begin
      exp_re = 1; exp_wr = 3; exp_done = 4;
    end

    @(negedge clk);
    check("ready_idle", {31'd0, out_ready}, 32'd1);
    in_req = 1'b1; in_we = we; in_address = addr; in_wd = wd;
    @(negedge clk);
    re_at = -1; wr_at = -1; done_at = -1; re_cnt = 0; wr_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      check("stall_busy", {31'd0, out_stall}, {31'd0, in_req});
      if (mem_re) begin
        re_cnt++; re_at = k;
        check("re_addr", mem_addr, word_addr);
      end
      if (mem_we) begin
        wr_cnt++; wr_at = k;
        check("we_addr", mem_addr, word_addr);
        check("we_data", mem_wd, exp_word);
      end
      if (out_done) begin
        done_at = k;
        check("err", {31'd0, out_err}, {31'd0, mis});
        check("out_rd", out_rd, (we == 2'b00 && !mis) ? old_word : exp_rd);
        break;
      end
      // Garbage on the request inputs while busy must be ignored.
      in_req = 1'($urandom_range(0, 1));
      in_we = 2'($urandom);
      in_address = $urandom;
      in_wd = $urandom;
      @(negedge clk);
    end
    in_req = 1'b0;
    check("done_cycle", done_at, exp_done);
    check("re_cycle", re_at, exp_re);
    check("we_cycle", wr_at, exp_wr);
    check("re_count", re_cnt, (exp_re > 0) ? 1 : 0);
    check("we_count", wr_cnt, (exp_wr > 0) ? 1 : 0);
    if (!mis) begin
      if (we == 2'b00) exp_rd = old_word;
      else             ref_mem[idx] = exp_word;
    end
    check("ram_word", ram_a[idx], ref_mem[idx]);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int re_at, wr_at, done_at;
    logic [31:0] wd_seen;
    logic [31:0] keep;

    rst_n = 1'b0;
    in_req = 1'b0; in_we = 2'b00; in_address = 32'd0; in_wd = 32'd0;
    in_req_b = 1'b0; in_we_b = 2'b00; in_address_b = 32'd0; in_wd_b = 32'd0;
    pre_we = 1'b0; pre_idx = 8'd0; pre_data = 32'd0;
    exp_rd = 32'd0;

    // Reset: every output low, including out_ready.
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'd0, out_ready}, 32'd0);
    check("rst_stall",  {31'd0, out_stall}, 32'd0);
    check("rst_done",   {31'd0, out_done}, 32'd0);
    check("rst_err",    {31'd0, out_err}, 32'd0);
    check("rst_rd",     out_rd, 32'd0);
    check("rst_re",     {31'd0, mem_re}, 32'd0);
    check("rst_we",     {31'd0, mem_we}, 32'd0);
    check("rst_wd",     mem_wd, 32'd0);
    check("rst_addr",   mem_addr, 32'd0);

    // Fill both RAMs and the model with random words while held in reset.
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    check("rst_ready_hold", {31'd0, out_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, out_ready}, 32'd1);

    // Word store.
    do_op(2'b11, 32'h100, 32'hDEADBEEF);
    check("t2_ram", ram_a[8'h40], 32'hDEADBEEF);

    // Byte store into lane 3.
    poke(8'h40, 32'h11223344);
    do_op(2'b01, 32'h103, 32'h000000AA);
    check("t3_ram", ram_a[8'h40], 32'hAA223344);

    // Upper half store, then load of the same word.
    poke(8'h80, 32'h11223344);
    do_op(2'b10, 32'h202, 32'h00005566);
    check("t4_ram", ram_a[8'h80], 32'h55663344);
    do_op(2'b00, 32'h200, 32'h0);
    check("t4_load", out_rd, 32'h55663344);

    // Misaligned half and word accesses with alignment checking on.
    do_op(2'b10, 32'h201, 32'h00007788);
    do_op(2'b00, 32'h302, 32'h0);
    do_op(2'b11, 32'h101, 32'hCAFEF00D);
    check("t5_rd_kept", out_rd, 32'h55663344);

    // Same misaligned half store with alignment checking off: normal RMW, lane [15:0].
    @(negedge clk);
    check("b_ready", {31'd0, out_ready_b}, 32'd1);
    in_req_b = 1'b1; in_we_b = 2'b10; in_address_b = 32'h201; in_wd_b = 32'h00005566;
    @(negedge clk);
    in_req_b = 1'b0;
    re_at = -1; wr_at = -1; done_at = -1; wd_seen = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_re_b) re_at = k;
      if (mem_we_b) begin wr_at = k; wd_seen = mem_wd_b; end
      if (out_done_b) begin
        done_at = k;
        check("b_err", {31'd0, out_err_b}, 32'd0);
        break;
      end
      @(negedge clk);
    end
    check("b_re_cycle", re_at, 1);
    check("b_we_cycle", wr_at, 3);
    check("b_done_cycle", done_at, 4);
    check("b_wd", wd_seen, 32'h11225566);
    check("b_ram", ram_b[8'h80], 32'h11225566);

    // Reset asserted in the WR cycle of a byte store: write dropped, no completion.
    keep = 32'h0BADCAFE;
    poke(8'hC0, keep);
    @(negedge clk);
    in_req = 1'b1; in_we = 2'b01; in_address = 32'h301; in_wd = 32'h000000EE;
    @(negedge clk);
    in_req = 1'b0;
    check("rst6_re", {31'd0, mem_re}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rst6_we_before", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst6_we_gated", {31'd0, mem_we}, 32'd0);
    check("rst6_ready", {31'd0, out_ready}, 32'd0);
    @(negedge clk);
    check("rst6_no_done", {31'd0, out_done}, 32'd0);
    check("rst6_no_we", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b1;
    exp_rd = 32'd0;
    #1;
    check("rst6_idle", {31'd0, out_ready}, 32'd1);
    check("rst6_ram", ram_a[8'hC0], keep);
    do_op(2'b00, 32'h300, 32'h0);
    check("rst6_load", out_rd, keep);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      do_op(2'($urandom_range(0, 3)), 32'($urandom_range(0, 1023)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
